// File: rtl/axis_acq_pkg.sv
// rtl/axis_acq_pkg.sv - shared state encoding for the triggered acquisition sequencer
package axis_acq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_DELAY = 3'd2,
    ST_ACQ   = 3'd3,
    ST_DONE  = 3'd4
  } acq_state_t;

endpackage

// File: rtl/axis_acq_out_reg.sv
// rtl/axis_acq_out_reg.sv - single-entry output register with load, accept and drop handling
module axis_acq_out_reg #(
  parameter int DATA_W = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              i_flush,
  input  logic              i_load_req,
  input  logic              i_load_last,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_tready,
  output logic [DATA_W-1:0] o_tdata,
  output logic              o_tvalid,
  output logic              o_tlast,
  output logic              o_loaded,
  output logic              o_dropped
);

  logic              r_valid;
  logic              r_last;
  logic [DATA_W-1:0] r_data;
  logic              w_accept;
  logic              w_can_load;

  // A slot can only be taken when the register is empty or is draining this cycle.
  assign w_accept   = r_valid & i_tready;
  assign w_can_load = ~r_valid | w_accept;
  assign o_loaded   = ~i_flush & i_load_req & w_can_load;
  assign o_dropped  = ~i_flush & i_load_req & ~w_can_load;

  assign o_tdata  = r_data;
  assign o_tvalid = r_valid;
  assign o_tlast  = r_last;

  // Holding register: load new slot, force tlast when the final slot is lost, clear on accept.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (o_loaded) begin
      r_valid <= 1'b1;
      r_last  <= i_load_last;
      r_data  <= i_load_data;
    end else if (o_dropped) begin
      if (i_load_last) begin
        r_last <= 1'b1;
      end
    end else if (w_accept) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_acq_sequencer.sv
// rtl/axis_acq_sequencer.sv - trigger, pre-delay and decimation sequencer for the ADC stream
module axis_acq_sequencer
  import axis_acq_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [CNTR_WIDTH-1:0]       cfg_ratio,
  input  logic [CNTR_WIDTH-1:0]       cfg_delay,
  input  logic [CNTR_WIDTH-1:0]       cfg_length,
  input  logic                        ctrl_start,
  input  logic                        ctrl_abort,
  input  logic                        trig_in,
  output logic                        sts_busy,
  output logic                        sts_done,
  output logic                        sts_overrun,
  output logic [CNTR_WIDTH-1:0]       sts_count,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast
);

  localparam logic [CNTR_WIDTH-1:0] ONE = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};

  acq_state_t            r_state;
  acq_state_t            w_state_nxt;
  logic                  r_trig_q;
  logic [CNTR_WIDTH-1:0] r_ratio;
  logic [CNTR_WIDTH-1:0] r_delay;
  logic [CNTR_WIDTH-1:0] r_length;
  logic [CNTR_WIDTH-1:0] r_delay_cnt;
  logic [CNTR_WIDTH-1:0] r_phase;
  logic [CNTR_WIDTH-1:0] r_slot;
  logic                  r_done;
  logic                  r_overrun;
  logic [CNTR_WIDTH-1:0] r_count;

  logic w_beat;
  logic w_trig_edge;
  logic w_start_ok;
  logic w_slot;
  logic w_last_slot;
  logic w_done_set;
  logic w_flush;
  logic w_out_valid;
  logic w_loaded;
  logic w_dropped;

  assign w_beat        = s_axis_tvalid;
  assign w_trig_edge   = trig_in & ~r_trig_q;
  assign s_axis_tready = 1'b1;
  assign sts_busy      = (r_state != ST_IDLE);
  assign sts_done      = r_done;
  assign sts_overrun   = r_overrun;
  assign sts_count     = r_count;
  assign m_axis_tvalid = w_out_valid;

  // State register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-cycle control strobes; abort overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_slot      = 1'b0;
    w_last_slot = 1'b0;
    w_done_set  = 1'b0;
    w_flush     = 1'b0;
    if (ctrl_abort) begin
      w_state_nxt = ST_IDLE;
      w_flush     = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ctrl_start && (cfg_length != '0)) begin
            w_start_ok  = 1'b1;
            w_state_nxt = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (w_trig_edge) begin
            w_state_nxt = (r_delay != '0) ? ST_DELAY : ST_ACQ;
          end
        end
        ST_DELAY: begin
          if (w_beat && (r_delay_cnt == r_delay - ONE)) begin
            w_state_nxt = ST_ACQ;
          end
        end
        ST_ACQ: begin
          if (w_beat && (r_phase == '0)) begin
            w_slot      = 1'b1;
            w_last_slot = (r_slot == r_length - ONE);
            if (w_last_slot) begin
              w_state_nxt = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (!w_out_valid || m_axis_tready) begin
            w_done_set  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Trigger history, sampled every cycle so only a fresh rising edge arms the delay.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_trig_q <= 1'b0;
    end else begin
      r_trig_q <= trig_in;
    end
  end

  // Latched burst configuration plus delay, phase and slot counters.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_ratio     <= ONE;
      r_delay     <= '0;
      r_length    <= '0;
      r_delay_cnt <= '0;
      r_phase     <= '0;
      r_slot      <= '0;
    end else begin
      if (w_start_ok) begin
        r_ratio  <= (cfg_ratio == '0) ? ONE : cfg_ratio;
        r_delay  <= cfg_delay;
        r_length <= cfg_length;
      end
      if (r_state == ST_IDLE || r_state == ST_ARMED) begin
        r_delay_cnt <= '0;
        r_phase     <= '0;
        r_slot      <= '0;
      end
      if (r_state == ST_DELAY && w_beat) begin
        r_delay_cnt <= r_delay_cnt + ONE;
      end
      if (r_state == ST_ACQ && w_beat) begin
        r_phase <= (r_phase == r_ratio - ONE) ? '0 : r_phase + ONE;
      end
      if (w_slot) begin
        r_slot <= r_slot + ONE;
      end
    end
  end

  // Sticky status, cleared only by an accepted start.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      r_count   <= '0;
    end else if (w_start_ok) begin
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      r_count   <= '0;
    end else begin
      if (w_done_set) begin
        r_done <= 1'b1;
      end
      if (w_dropped) begin
        r_overrun <= 1'b1;
      end
      if (w_loaded) begin
        r_count <= r_count + ONE;
      end
    end
  end

  axis_acq_out_reg #(
    .DATA_W (AXIS_TDATA_WIDTH)
  ) u_out_reg (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .i_flush     (w_flush),
    .i_load_req  (w_slot),
    .i_load_last (w_last_slot),
    .i_load_data (s_axis_tdata),
    .i_tready    (m_axis_tready),
    .o_tdata     (m_axis_tdata),
    .o_tvalid    (w_out_valid),
    .o_tlast     (m_axis_tlast),
    .o_loaded    (w_loaded),
    .o_dropped   (w_dropped)
  );

endmodule

// File: tb/tb_axis_acq_sequencer.sv
// tb/tb_axis_acq_sequencer.sv - reference-model and directed checks for axis_acq_sequencer
module tb_axis_acq_sequencer;

  logic        aclk;
  logic        aresetn;
  logic [31:0] cfg_ratio;
  logic [31:0] cfg_delay;
  logic [31:0] cfg_length;
  logic        ctrl_start;
  logic        ctrl_abort;
  logic        trig_in;
  logic        sts_busy;
  logic        sts_done;
  logic        sts_overrun;
  logic [31:0] sts_count;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;

  axis_acq_sequencer #(
    .AXIS_TDATA_WIDTH (32),
    .CNTR_WIDTH       (32)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_ratio     (cfg_ratio),
    .cfg_delay     (cfg_delay),
    .cfg_length    (cfg_length),
    .ctrl_start    (ctrl_start),
    .ctrl_abort    (ctrl_abort),
    .trig_in       (trig_in),
    .sts_busy      (sts_busy),
    .sts_done      (sts_done),
    .sts_overrun   (sts_overrun),
    .sts_count     (sts_count),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 0;

  logic [31:0] cap_data[$];
  bit          cap_last[$];

  // Reference model: mode 0 idle, 1 waiting for trigger, 2 running, 3 draining.
  int          m_mode  = 0;
  bit          m_tq    = 0;
  longint      m_ratio = 1;
  longint      m_delay = 0;
  longint      m_len   = 0;
  longint      m_j     = 0;
  bit          m_valid = 0;
  bit          m_last  = 0;
  logic [31:0] m_data  = '0;
  bit          m_done  = 0;
  bit          m_ovr   = 0;
  int          m_cnt   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit     acc;
    bit     e_s;
    bit     loaded;
    bit     islast;
    longint k;
    if (!aresetn) begin
      m_mode = 0; m_tq = 0; m_valid = 0; m_last = 0; m_data = '0;
      m_done = 0; m_ovr = 0; m_cnt = 0; m_j = 0;
      return;
    end
    acc    = m_valid && m_axis_tready;
    e_s    = trig_in && !m_tq;
    m_tq   = trig_in;
    loaded = 0;
    if (ctrl_abort) begin
      m_mode = 0; m_valid = 0; m_last = 0;
      return;
    end
    case (m_mode)
      0: if (ctrl_start && cfg_length != 0) begin
           m_ratio = (cfg_ratio == 0) ? 1 : longint'(cfg_ratio);
           m_delay = longint'(cfg_delay);
           m_len   = longint'(cfg_length);
           m_done = 0; m_ovr = 0; m_cnt = 0; m_mode = 1;
         end
      1: if (e_s) begin m_mode = 2; m_j = 0; end
      2: if (s_axis_tvalid) begin
           if (m_j >= m_delay && ((m_j - m_delay) % m_ratio) == 0) begin
             k      = (m_j - m_delay) / m_ratio;
             islast = (k == m_len - 1);
             if (!m_valid || acc) begin
               m_data = s_axis_tdata; m_valid = 1; m_last = islast; m_cnt++; loaded = 1;
             end else begin
               m_ovr = 1;
               if (islast) m_last = 1;
             end
             if (islast) m_mode = 3;
           end
           m_j++;
         end
      3: if (!m_valid || acc) begin m_done = 1; m_mode = 0; end
      default: m_mode = 0;
    endcase
    if (acc && !loaded) begin m_valid = 0; m_last = 0; end
  endtask

  // Per-cycle comparison against the model, then advance the model with this cycle's inputs.
  always @(negedge aclk) begin
    if (cmp_en) begin
      check("tvalid", 64'(m_axis_tvalid), 64'(m_valid));
      check("busy", 64'(sts_busy), 64'(m_mode != 0));
      check("done", 64'(sts_done), 64'(m_done));
      check("overrun", 64'(sts_overrun), 64'(m_ovr));
      check("count", 64'(sts_count), 64'(m_cnt));
      check("tready_in", 64'(s_axis_tready), 64'd1);
      if (m_valid) begin
        check("tdata", 64'(m_axis_tdata), 64'(m_data));
        check("tlast", 64'(m_axis_tlast), 64'(m_last));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        cap_data.push_back(m_axis_tdata);
        cap_last.push_back(m_axis_tlast);
      end
    end
    model_step();
  end

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    bit found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge aclk);
      if (!sts_busy) found = 1;
    end
    check(name, 64'(found), 64'd1);
  endtask

  task automatic check_cap(input string name, input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input int n, input int last_idx);
    logic [31:0] exp_d[3];
    exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2;
    check({name, "_n"}, 64'(cap_data.size()), 64'(n));
    for (int i = 0; i < n && i < cap_data.size(); i++) begin
      check({name, "_data"}, 64'(cap_data[i]), 64'(exp_d[i]));
      check({name, "_last"}, 64'(cap_last[i]), 64'(i == last_idx));
    end
  endtask

  task automatic arm(input int r, input int d, input int l, input bit tr);
    cyc();
    cfg_ratio = 32'(r); cfg_delay = 32'(d); cfg_length = 32'(l);
    ctrl_start = 1; trig_in = tr; s_axis_tvalid = 1; s_axis_tdata = 32'd999;
    cap_data.delete(); cap_last.delete();
  endtask

  initial begin
    aresetn = 0; cfg_ratio = 0; cfg_delay = 0; cfg_length = 0;
    ctrl_start = 0; ctrl_abort = 0; trig_in = 0;
    s_axis_tdata = 0; s_axis_tvalid = 0; m_axis_tready = 1;
    repeat (3) cyc();
    @(negedge aclk);
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_tdata", 64'(m_axis_tdata), 64'd0);
    check("rst_sts", {sts_busy, sts_done, sts_overrun, sts_count}, 64'd0);
    check("rst_tready", 64'(s_axis_tready), 64'd1);
    cyc();
    aresetn = 1;
    cmp_en  = 1;

    // ratio 4, no delay, 3 slots, edge on beat 0
    m_axis_tready = 1;
    arm(4, 0, 3, 0);
    cyc(); ctrl_start = 0; trig_in = 1; s_axis_tdata = 0;
    for (int n = 1; n < 16; n++) begin cyc(); s_axis_tdata = 32'(n); end
    cyc(); s_axis_tvalid = 0;
    wait_idle("t1_idle");
    check_cap("t1", 32'd1, 32'd5, 32'd9, 3, 2);
    check("t1_count", 64'(sts_count), 64'd3);
    check("t1_done", 64'(sts_done), 64'd1);

    // ratio 0 acts as 1, delay 2, edge on beat 10
    arm(0, 2, 2, 0);
    for (int n = 0; n < 20; n++) begin
      cyc(); ctrl_start = 0; s_axis_tdata = 32'(n); trig_in = (n >= 10);
    end
    cyc(); s_axis_tvalid = 0;
    wait_idle("t2_idle");
    check_cap("t2", 32'd13, 32'd14, 32'd0, 2, 1);

    // permanent backpressure: first sample held, rest dropped, tlast forced
    m_axis_tready = 0;
    arm(1, 0, 3, 0);
    cyc(); ctrl_start = 0; trig_in = 1; s_axis_tdata = 0;
    for (int n = 1; n < 7; n++) begin cyc(); s_axis_tdata = 32'(n); end
    @(negedge aclk);
    check("t3_busy", 64'(sts_busy), 64'd1);
    check("t3_held", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {32'd0, 1'b1, 1'b1, 32'd1});
    check("t3_ovr", 64'(sts_overrun), 64'd1);
    check("t3_count", 64'(sts_count), 64'd1);
    cyc(); m_axis_tready = 1;
    wait_idle("t3_idle");
    check_cap("t3", 32'd1, 32'd0, 32'd0, 1, 0);
    check("t3_done", 64'(sts_done), 64'd1);

    // abort while a beat is pending
    m_axis_tready = 0;
    arm(1, 0, 10, 0);
    cyc(); ctrl_start = 0; trig_in = 1; s_axis_tdata = 0;
    cyc(); s_axis_tdata = 1;
    cyc(); s_axis_tdata = 2;
    cyc(); s_axis_tdata = 3; ctrl_abort = 1;
    cyc(); ctrl_abort = 0;
    @(negedge aclk);
    check("t4_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("t4_busy", 64'(sts_busy), 64'd0);
    check("t4_done", 64'(sts_done), 64'd0);

    // trigger already high at start must not count as an edge
    m_axis_tready = 1;
    cyc(); trig_in = 0;
    arm(1, 0, 2, 1);
    for (int n = 0; n < 6; n++) begin cyc(); ctrl_start = 0; s_axis_tdata = 32'(100 + n); end
    @(negedge aclk);
    check("t5_armed", 64'(sts_busy), 64'd1);
    check("t5_nodata", 64'(cap_data.size()), 64'd0);
    cyc(); trig_in = 0; s_axis_tdata = 200;
    cyc(); trig_in = 1; s_axis_tdata = 201;
    cyc(); s_axis_tdata = 202;
    cyc(); s_axis_tdata = 203;
    cyc(); s_axis_tvalid = 0;
    wait_idle("t5_idle");
    check_cap("t5", 32'd202, 32'd203, 32'd0, 2, 1);
    cyc(); ctrl_start = 1; cfg_length = 0;
    cyc(); ctrl_start = 0;
    @(negedge aclk);
    check("t5_len0", 64'(sts_busy), 64'd0);

    // reset in the middle of acquisition
    arm(1, 0, 20, 0);
    cyc(); ctrl_start = 0; trig_in = 1; s_axis_tdata = 0;
    for (int n = 1; n < 5; n++) begin cyc(); s_axis_tdata = 32'(n); end
    aresetn = 0;
    cyc(); aresetn = 1;
    @(negedge aclk);
    check("t6_out", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, 64'd0);
    check("t6_sts", {sts_busy, sts_done, sts_overrun, sts_count}, 64'd0);

    // randomized traffic against the model
    for (int c = 0; c < 5000; c++) begin
      cyc();
      aresetn       = ($urandom_range(0, 699) != 0);
      ctrl_start    = ($urandom_range(0, 19) == 0);
      ctrl_abort    = ($urandom_range(0, 149) == 0);
      cfg_ratio     = $urandom_range(0, 4);
      cfg_delay     = $urandom_range(0, 5);
      cfg_length    = $urandom_range(0, 6);
      if ($urandom_range(0, 5) == 0) trig_in = ~trig_in;
      s_axis_tvalid = ($urandom_range(0, 3) != 0);
      s_axis_tdata  = $urandom;
      m_axis_tready = ($urandom_range(0, 2) != 0);
    end
    cyc();
    aresetn = 1; ctrl_start = 0; ctrl_abort = 0;
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_acq_sequencer.md
# axis_acq_sequencer

Triggered burst-acquisition controller for the ADC sample path. Gates a free-running AXI-Stream, waits for a trigger edge, skips a programmable pre-delay, then emits every Nth sample (decimation) for a programmed number of output samples, closing the burst with tlast. It sits between the ADC stream and the DMA/FIFO writer, and presents start/abort control and status to the PS register bank.

## Interface
- AXIS_TDATA_WIDTH, 32, sample width
- CNTR_WIDTH, 32, width of ratio/delay/length/count fields
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  reset, synchronous, active-low
- cfg_ratio  in  CNTR_WIDTH  decimation ratio; 0 treated as 1
- cfg_delay  in  CNTR_WIDTH  input beats skipped after trigger
- cfg_length  in  CNTR_WIDTH  output slots per burst
- ctrl_start  in  1  one-cycle pulse; latches cfg_*, arms
- ctrl_abort  in  1  return to IDLE immediately
- trig_in  in  1  synchronous trigger level; rising edge used
- sts_busy  out  1  state != IDLE
- sts_done  out  1  sticky, burst completed
- sts_overrun  out  1  sticky, sample dropped due to backpressure
- sts_count  out  CNTR_WIDTH  samples actually emitted this burst
- s_axis_tdata  in  AXIS_TDATA_WIDTH  input sample
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  constant 1; ADC source never stalled
- m_axis_tdata  out  AXIS_TDATA_WIDTH  output sample
- m_axis_tvalid  out  1  registered; never depends on m_axis_tready
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  marks final beat of burst

## Operation
- States: IDLE, ARMED, DELAY, ACQ, DONE. "Beat" = cycle with s_axis_tvalid=1.
- IDLE: beats discarded. ctrl_start with cfg_length!=0 -> latch cfg_* (ratio 0 -> 1), clear sts_done/sts_overrun/sts_count, -> ARMED. Start with cfg_length=0 ignored.
- Trigger edge = trig_in & ~trig_q; trig_q reset 0, updated every cycle. Evaluated only in ARMED; edge in the start cycle is not seen.
- ARMED: on edge -> DELAY if delay!=0, else ACQ. Beat in the edge cycle is discarded.
- DELAY: count beats; after delay-th beat -> ACQ.
- ACQ: phase counter starts 0, increments per beat, wraps at ratio-1. Beat at phase 0 is a slot; slot counter increments per slot. Slot length-1 is the last -> DONE.
- Slot load: if output register empty or accepted this cycle, load tdata, tlast=(last slot), sts_count+1. Otherwise drop sample, set sts_overrun; if dropped slot is the last, set tlast on the held beat.
- DONE: wait until output register empty, then set sts_done, -> IDLE.
- ctrl_abort, any state: -> IDLE next cycle, m_axis_tvalid cleared, sts_done not set. Abort beats start in the same cycle. Start while busy ignored.
- Counters are CNTR_WIDTH unsigned; comparisons use latched values; mid-burst cfg_* changes have no effect.

## Timing
- Reset: state IDLE, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, sts_*=0, trig_q=0; s_axis_tready=1 always.
- Latency: slot beat at cycle t -> m_axis_tvalid at t+1.
- Output held stable while tvalid & ~tready (tdata, tlast unchanged except forced tlast on dropped last slot).
- Throughput: ratio=1 with tready=1 emits one beat per cycle, no bubbles.
- sts_done rises the cycle after the tlast beat is accepted.

## Structure
- Package axis_acq_pkg: state localparams (3-bit, IDLE=0..DONE=4), STATE_W.
- Sub-module axis_acq_out_reg: single-entry output register with load/accept/drop logic and overrun/tlast-force outputs.
- Top: FSM, trigger edge detector, phase/delay/slot counters.

## Test plan
- ratio=4, delay=0, length=3, tready=1, continuous beats data=n: outputs samples 1,5,9 after edge at beat 0; tlast on 9; sts_count=3; sts_done=1.
- ratio=0, delay=2, length=2: treated as ratio 1; edge at beat 10 -> outputs 13,14; tlast on 14.
- tready=0 throughout, ratio=1, length=3: first sample held, two dropped, sts_overrun=1, tlast forced on held beat, sts_count=1; done after tready=1.
- ctrl_abort in ACQ with beat pending: m_axis_tvalid=0 next cycle, state IDLE, sts_done=0.
- trig_in high in the start cycle and held: no trigger until low then high; start with cfg_length=0 leaves sts_busy=0.
- Reset asserted mid-ACQ: all outputs return to reset values next cycle.
